// File: rtl/mod_counter_seq_ctrl.sv
// Run-control sequencer for the mod-MOD counter: STOP/RUN/STEP/CLEAR over
// valid/ready, drives counter enable/clear and ends a RUN after N wraps.
module mod_counter_seq_ctrl #(
  parameter int MOD   = 6,
  parameter int CW    = 3,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WRAPW-1:0] cmd_cycles,
  input  logic [CW-1:0]    cnt_val,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic [WRAPW-1:0] wrap_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_CLR,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  state_e           state_q, state_d;
  logic [WRAPW-1:0] target_q, target_d;
  logic [WRAPW-1:0] wrap_count_q, wrap_count_d;

  logic             accept;
  logic             wrap;
  logic             terminal;
  logic [WRAPW:0]   wc_p1;
  logic [WRAPW-1:0] wc_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign cnt_en     = (state_q == S_RUN) || (state_q == S_STEP);
  assign cnt_clr    = (state_q == S_CLR);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN);
  assign wrap_count = wrap_count_q;

  assign accept = cmd_valid && cmd_ready;
  // Out-of-range counter values never equal LAST, so they never wrap.
  assign wrap   = cnt_en && (cnt_val == LAST);
  assign wc_p1  = {1'b0, wrap_count_q} + (WRAPW+1)'(1);
  assign wc_sat = (&wrap_count_q) ? wrap_count_q : wc_p1[WRAPW-1:0];

  assign terminal = (target_q != '0) && wrap &&
                    (wc_p1 == {1'b0, target_q});

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    wrap_count_d = wrap_count_q;
    if (wrap) begin
      wrap_count_d = wc_sat;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_RUN: begin
              target_d     = cmd_cycles;
              wrap_count_d = '0;
              state_d      = S_RUN;
            end
            OP_STEP:  state_d = S_STEP;
            OP_CLEAR: state_d = S_CLR;
            OP_STOP:  state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        // Reaching the target beats any command arriving the same cycle.
        if (terminal) begin
          state_d = S_DONE;
        end else if (accept && cmd_op == OP_CLEAR) begin
          state_d = S_CLR;
        end else if (accept && cmd_op == OP_STOP) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: state_d = S_IDLE;
      S_CLR: begin
        wrap_count_d = '0;
        state_d      = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_counter_seq_ctrl.sv
// Bench for mod_counter_seq_ctrl: a behavioural mod-6 counter closes the loop,
// RUN transactions are checked against arithmetic wrap/cycle expectations.
module tb_mod_counter_seq_ctrl;

  localparam int MOD = 6;
  localparam int NEVER = 100000;

  logic       clk = 0;
  logic       rst = 1;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_cycles = 0;
  logic [2:0] cnt_val;
  logic       cnt_en, cnt_clr, busy, done;
  logic [7:0] wrap_count;

  logic       ld = 0;
  logic [2:0] ld_val = 0;
  logic [2:0] ctr = 0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int v;
    int t;
    int k;
    int en;
    int dn;
    int wc;
  } vec_t;

  vec_t vecs[6];

  mod_counter_seq_ctrl #(.MOD(6), .CW(3), .WRAPW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cycles(cmd_cycles),
    .cnt_val(cnt_val), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .busy(busy), .done(done), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) ctr <= ld_val;
    else if (cnt_clr) ctr <= 0;
    else if (cnt_en) ctr <= (ctr == 3'(MOD - 1)) ? 3'd0 : ctr + 3'd1;
  end
  assign cnt_val = ctr;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int v);
    ld = 1;
    ld_val = 3'(v);
    cyc();
    ld = 0;
  endtask

  task automatic send(input logic [1:0] op, input int cyc_n);
    cmd_valid = 1;
    cmd_op = op;
    cmd_cycles = 8'(cyc_n);
    cyc();
    cmd_valid = 0;
  endtask

  // RUN from counter value v with target t; STOP shown on enabled cycle k.
  task automatic run_txn(input int v, input int t, input int k,
                         input bit noise,
                         output int en, output int dn, output int wc);
    bit to;
    en = 0;
    dn = 0;
    to = 1;
    load(v);
    send(2'b01, t);
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = 0;
      if (!busy) begin
        to = 0;
        break;
      end
      if (done) dn++;
      if (cnt_en) begin
        en++;
        if (en == k) begin
          cmd_valid = 1;
          cmd_op = 2'b00;
        end else if (noise && $urandom_range(0, 3) == 0) begin
          cmd_valid = 1;
          cmd_op = $urandom_range(0, 1) ? 2'b01 : 2'b10;
          cmd_cycles = 8'($urandom_range(0, 255));
        end
      end
      cyc();
    end
    if (to) chk("txn_timeout", 1, 0);
    wc = wrap_count;
  endtask

  initial begin
    int en, dn, wc;
    int v, t, k, full, e_en, e_dn, e_wc;

    vecs[0] = '{v: 0, t: 2, k: NEVER, en: 12,   dn: 1, wc: 2};
    vecs[1] = '{v: 0, t: 0, k: 20,    en: 20,   dn: 0, wc: 3};
    vecs[2] = '{v: 5, t: 1, k: 1,     en: 1,    dn: 1, wc: 1};
    vecs[3] = '{v: 0, t: 0, k: 1600,  en: 1600, dn: 0, wc: 255};
    vecs[4] = '{v: 3, t: 2, k: NEVER, en: 9,    dn: 1, wc: 2};
    vecs[5] = '{v: 2, t: 3, k: 4,     en: 4,    dn: 0, wc: 1};

    rst = 1;
    cyc();
    cyc();
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_wc", wrap_count, 0);
    rst = 0;
    cyc();

    send(2'b01, 2);
    chk("run_latency_en", cnt_en, 1);
    chk("run_busy", busy, 1);
    cmd_valid = 1;
    cmd_op = 2'b00;
    cyc();
    cmd_valid = 0;
    chk("stop_idle", busy, 0);
    load(0);

    foreach (vecs[i]) begin
      run_txn(vecs[i].v, vecs[i].t, vecs[i].k, 0, en, dn, wc);
      chk($sformatf("vec%0d_en", i), en, vecs[i].en);
      chk($sformatf("vec%0d_done", i), dn, vecs[i].dn);
      chk($sformatf("vec%0d_wc", i), wc, vecs[i].wc);
      chk($sformatf("vec%0d_en_off", i), cnt_en, 0);
    end

    send(2'b11, 0);
    chk("clr_pulse", cnt_clr, 1);
    chk("clr_ready", cmd_ready, 0);
    chk("clr_en", cnt_en, 0);
    chk("clr_busy", busy, 1);
    cyc();
    chk("clr_end", cnt_clr, 0);
    chk("clr_wc", wrap_count, 0);
    load(5);
    send(2'b10, 0);
    chk("step_en", cnt_en, 1);
    chk("step_done", done, 0);
    cyc();
    chk("step_en_off", cnt_en, 0);
    chk("step_wc", wrap_count, 1);
    chk("step_idle", busy, 0);
    chk("step_no_done", done, 0);
    chk("step_ctr", cnt_val, 0);
    send(2'b11, 0);
    chk("clr2_pulse", cnt_clr, 1);
    cyc();
    chk("clr2_wc", wrap_count, 0);

    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, MOD - 1);
      t = $urandom_range(0, 4);
      k = $urandom_range(1, 40);
      if (t != 0 && $urandom_range(0, 1) == 1) k = NEVER;
      full = MOD * t - v;
      if (t != 0 && full <= k) begin
        e_en = full;
        e_dn = 1;
        e_wc = t;
      end else begin
        e_en = k;
        e_dn = 0;
        e_wc = (v + k) / MOD;
        if (e_wc > 255) e_wc = 255;
      end
      run_txn(v, t, k, 1, en, dn, wc);
      chk($sformatf("rnd%0d_en v=%0d t=%0d k=%0d", i, v, t, k), en, e_en);
      chk($sformatf("rnd%0d_done", i), dn, e_dn);
      chk($sformatf("rnd%0d_wc", i), wc, e_wc);
    end

    load(0);
    send(2'b01, 0);
    repeat (8) cyc();
    chk("mid_wc", wrap_count, 1);
    chk("mid_en", cnt_en, 1);
    #2 rst = 1;
    #1;
    chk("arst_en", cnt_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_clr", cnt_clr, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_wc", wrap_count, 0);
    @(posedge clk);
    #1 rst = 0;
    cyc();
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
